// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which pipeline port owns the access in flight
//   MAX_RAM_LAT : largest supported RAM read latency
//   LAT_CNT_W   : width of the latency down-counter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;

    localparam int unsigned MAX_RAM_LAT = 7;
    localparam int unsigned LAT_CNT_W   = $clog2(MAX_RAM_LAT + 1);

endpackage

// File: rtl/arb_lat_counter.sv
// Loadable down-counter with a zero flag; counts RAM latency cycles.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one, holding at zero
//   count     : current count
//   zero      : count == 0
module arb_lat_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    assign zero = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between the IF fetch port and
// the MEM load/store port. MEM has priority (older instruction). Each access
// runs IDLE -> ISSUE -> [WAIT] -> DONE, then a one-cycle valid pulse during
// which no new grant is made.
// Optional: define ARB_STARVE_GUARD_EN to force an IF grant after STARVE_MAX
// consecutive MEM grants taken while IF was waiting.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   if_req/if_addr                   : fetch request (level) and word address
//   if_rdata/if_valid/stall_if       : fetch data, completion pulse, stall
//   mem_req/mem_we/mem_addr/mem_wdata: data request (level), store flag, addr, data
//   mem_rdata/mem_valid/stall_mem    : load data, completion pulse, stall
//   ram_en/ram_we/ram_addr/ram_wdata : RAM strobes, address and write data
//   ram_rdata                        : RAM read data, RAM_LAT cycles after ram_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RAM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    if (RAM_LAT < 1 || RAM_LAT > MAX_RAM_LAT || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: RAM_LAT must be 1..7 and STARVE_MAX >= 1");
    end

    arb_state_t          state, state_nxt;
    arb_owner_t          owner;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                grant_if, grant_mem;
    logic                bubble;
    logic                issue;
    logic                lat_load, lat_dec, lat_zero;
    logic [LAT_CNT_W-1:0] lat_cnt;

    // The valid cycle is the post-DONE bubble: the requester still holds its
    // old request there, so it must not be re-granted.
    assign bubble = if_valid | mem_valid;

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_hit;

    assign starve_hit = (starve_cnt == STARVE_W'(STARVE_MAX));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_mem && if_req && !starve_hit) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`endif

    always_comb begin
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        if (state == IDLE && !bubble) begin
`ifdef ARB_STARVE_GUARD_EN
            if (mem_req && !(if_req && starve_hit)) begin
`else
            if (mem_req) begin
`endif
                grant_mem = 1'b1;
            end else if (if_req) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        lat_load  = 1'b0;
        lat_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_mem || grant_if) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                lat_load  = 1'b1;
                state_nxt = (RAM_LAT == 1) ? DONE : WAIT;
            end
            WAIT: begin
                lat_dec = 1'b1;
                // Leave on the decrement that reaches zero.
                if (lat_cnt == LAT_CNT_W'(1) || lat_zero) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    arb_lat_counter #(
        .WIDTH(LAT_CNT_W)
    ) u_lat_counter (
        .clk     (clk),
        .rst     (rst),
        .load    (lat_load),
        .load_val(LAT_CNT_W'(RAM_LAT - 1)),
        .dec     (lat_dec),
        .count   (lat_cnt),
        .zero    (lat_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= state_nxt;
            if_valid  <= (state == DONE) && (owner == OWN_IF);
            mem_valid <= (state == DONE) && (owner == OWN_MEM);
            if (grant_mem) begin
                owner   <= OWN_MEM;
                addr_q  <= mem_addr;
                we_q    <= mem_we;
                wdata_q <= mem_wdata;
            end else if (grant_if) begin
                owner   <= OWN_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
            if (state == DONE) begin
                if (owner == OWN_IF) begin
                    if_rdata <= ram_rdata;
                end else if (!we_q) begin
                    mem_rdata <= ram_rdata;
                end
            end
        end
    end

    assign issue     = (state == ISSUE);
    assign ram_en    = issue;
    assign ram_we    = issue & we_q;
    assign ram_addr  = issue ? addr_q  : '0;
    assign ram_wdata = issue ? wdata_q : '0;

    // Gated by rst so every output reads 0 while reset is held.
    assign stall_if  = rst & if_req  & ~if_valid;
    assign stall_mem = rst & mem_req & ~mem_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req    [2];
    logic [AW-1:0] if_addr   [2];
    logic [DW-1:0] if_rdata  [2];
    logic          if_valid  [2];
    logic          stall_if  [2];
    logic          mem_req   [2];
    logic          mem_we    [2];
    logic [AW-1:0] mem_addr  [2];
    logic [DW-1:0] mem_wdata [2];
    logic [DW-1:0] mem_rdata [2];
    logic          mem_valid [2];
    logic          stall_mem [2];
    logic          ram_en    [2];
    logic          ram_we    [2];
    logic [AW-1:0] ram_addr  [2];
    logic [DW-1:0] ram_wdata [2];
    logic [DW-1:0] ram_rdata [2];

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT0), .STARVE_MAX(4)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]),
        .if_valid(if_valid[0]), .stall_if(stall_if[0]),
        .mem_req(mem_req[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .mem_valid(mem_valid[0]), .stall_mem(stall_mem[0]),
        .ram_en(ram_en[0]), .ram_we(ram_we[0]), .ram_addr(ram_addr[0]),
        .ram_wdata(ram_wdata[0]), .ram_rdata(ram_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(LAT1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]),
        .if_valid(if_valid[1]), .stall_if(stall_if[1]),
        .mem_req(mem_req[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .mem_valid(mem_valid[1]), .stall_mem(stall_mem[1]),
        .ram_en(ram_en[1]), .ram_we(ram_we[1]), .ram_addr(ram_addr[1]),
        .ram_wdata(ram_wdata[1]), .ram_rdata(ram_rdata[1])
    );

    // Behavioural RAMs: read data appears LAT cycles after ram_en, and is
    // zero otherwise so a mistimed sample is caught.
    logic [DW-1:0] ram  [2][1024];
    logic [DW-1:0] pipe [2][8];
    logic          poke_en;
    int            poke_d;
    logic [AW-1:0] poke_a;
    logic [DW-1:0] poke_v;

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ram_en[d] && ram_we[d]) ram[d][ram_addr[d]] <= ram_wdata[d];
            pipe[d][0] <= ram_en[d] ? ram[d][ram_addr[d]] : '0;
            for (int k = 1; k < 8; k++) pipe[d][k] <= pipe[d][k-1];
        end
        if (poke_en) ram[poke_d][poke_a] <= poke_v;
    end

    assign ram_rdata[0] = pipe[0][LAT0-1];
    assign ram_rdata[1] = pipe[1][LAT1-1];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input int d, input logic [AW-1:0] a, input logic [DW-1:0] v);
        poke_d = d; poke_a = a; poke_v = v; poke_en = 1'b1;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, " if_rdata"},  if_rdata[d], 32'h0);
        chk({tag, " mem_rdata"}, mem_rdata[d], 32'h0);
        chk({tag, " ctrl"}, {26'h0, if_valid[d], stall_if[d], mem_valid[d],
                             stall_mem[d], ram_en[d], ram_we[d]}, 32'h0);
        chk({tag, " ram_addr"},  {22'h0, ram_addr[d]}, 32'h0);
        chk({tag, " ram_wdata"}, ram_wdata[d], 32'h0);
    endtask

    // One access on port IF or MEM of instance d, observed cycle by cycle
    // (cycle 0 = first cycle the request is visible).
    task automatic access(input int d, input bit is_mem, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] wd,
                          output int vcyc, output logic [DW-1:0] rd,
                          output int en_n, output int en_cyc,
                          output logic [AW-1:0] en_addr, output logic en_we,
                          output int st_n);
        @(posedge clk); #1;
        if (is_mem) begin
            mem_req[d] = 1'b1; mem_we[d] = we; mem_addr[d] = a; mem_wdata[d] = wd;
        end else begin
            if_req[d] = 1'b1; if_addr[d] = a;
        end
        vcyc = -1; rd = '0; en_n = 0; en_cyc = -1; en_addr = '0; en_we = 1'b0; st_n = 0;
        for (int c = 0; c < 40 && vcyc < 0; c++) begin
            @(negedge clk);
            if (ram_en[d]) begin
                en_n++; en_cyc = c; en_addr = ram_addr[d]; en_we = ram_we[d];
            end
            if (is_mem ? stall_mem[d] : stall_if[d]) st_n++;
            if (is_mem ? mem_valid[d] : if_valid[d]) begin
                vcyc = c;
                rd = is_mem ? mem_rdata[d] : if_rdata[d];
            end
            @(posedge clk); #1;
        end
        if (is_mem) begin
            mem_req[d] = 1'b0; mem_we[d] = 1'b0;
        end else begin
            if_req[d] = 1'b0;
        end
    endtask

    typedef struct {
        int            d;
        bit            is_mem;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vc, en_n, en_c, st_n, lat;
        logic [DW-1:0] rd;
        logic [AW-1:0] en_a;
        logic en_w;
        int mv, iv, ien, men, sif, mem_g, if_g_at, nvalid;
        logic mvn, ivn, stop;
        logic [DW-1:0] ird;
        logic [AW-1:0] ea;

        vecs[0]  = '{0, 1'b0, 1'b0, 10'h004, 32'h0,        32'h2402000A};
        vecs[1]  = '{0, 1'b1, 1'b1, 10'h030, 32'hCAFEF00D, 32'h00000000};
        vecs[2]  = '{0, 1'b1, 1'b0, 10'h030, 32'h0,        32'hCAFEF00D};
        vecs[3]  = '{0, 1'b0, 1'b0, 10'h030, 32'h0,        32'hCAFEF00D};
        vecs[4]  = '{0, 1'b1, 1'b1, 10'h3FF, 32'hA5A5A5A5, 32'hCAFEF00D};
        vecs[5]  = '{0, 1'b1, 1'b0, 10'h3FF, 32'h0,        32'hA5A5A5A5};
        vecs[6]  = '{0, 1'b1, 1'b0, 10'h000, 32'h0,        32'h11111111};
        vecs[7]  = '{1, 1'b1, 1'b0, 10'h020, 32'h0,        32'h12345678};
        vecs[8]  = '{1, 1'b1, 1'b1, 10'h021, 32'h0F0F0F0F, 32'h12345678};
        vecs[9]  = '{1, 1'b0, 1'b0, 10'h021, 32'h0,        32'h0F0F0F0F};
        vecs[10] = '{1, 1'b0, 1'b0, 10'h020, 32'h0,        32'h12345678};

        rst = 1'b0; poke_en = 1'b0; poke_d = 0; poke_a = '0; poke_v = '0;
        for (int d = 0; d < 2; d++) begin
            if_req[d] = 1'b0; if_addr[d] = '0; mem_req[d] = 1'b0; mem_we[d] = 1'b0;
            mem_addr[d] = '0; mem_wdata[d] = '0;
        end

        @(posedge clk); #1;
        poke(0, 10'h004, 32'h2402000A);
        poke(0, 10'h000, 32'h11111111);
        poke(0, 10'h010, 32'h00000000);
        poke(1, 10'h020, 32'h12345678);
        poke(1, 10'h004, 32'h55AA55AA);

        // Reset state, with requests raised to show stalls are held low.
        if_req[0] = 1'b1; mem_req[0] = 1'b1;
        #1;
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        if_req[0] = 1'b0; mem_req[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Single accesses from the table.
        foreach (vecs[i]) begin
            lat = (vecs[i].d == 0) ? LAT0 : LAT1;
            access(vecs[i].d, vecs[i].is_mem, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vc, rd, en_n, en_c, en_a, en_w, st_n);
            chk($sformatf("v%0d valid_cycle", i), vc, 2 + lat);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d ram_en_count", i), en_n, 1);
            chk($sformatf("v%0d ram_en_cycle", i), en_c, 1);
            chk($sformatf("v%0d ram_addr", i), {22'h0, en_a}, {22'h0, vecs[i].addr});
            chk($sformatf("v%0d ram_we", i), {31'h0, en_w}, {31'h0, vecs[i].we});
            chk($sformatf("v%0d stall_cycles", i), st_n, 2 + lat);
        end

        // Simultaneous requests: MEM store first, then IF after one bubble.
        @(posedge clk); #1;
        mem_req[0] = 1'b1; mem_we[0] = 1'b1; mem_addr[0] = 10'h010; mem_wdata[0] = 32'hDEADBEEF;
        if_req[0] = 1'b1; if_addr[0] = 10'h004;
        mv = -1; iv = -1; ien = -1; men = -1; sif = 0; ird = '0;
        for (int c = 0; c < 30 && iv < 0; c++) begin
            @(negedge clk);
            if (ram_en[0]) begin
                if (ram_we[0] && ram_addr[0] == 10'h010) men = c;
                else if (!ram_we[0] && ram_addr[0] == 10'h004) ien = c;
            end
            if (stall_if[0]) sif++;
            if (mem_valid[0]) mv = c;
            if (if_valid[0]) begin iv = c; ird = if_rdata[0]; end
            mvn = mem_valid[0]; ivn = if_valid[0];
            @(posedge clk); #1;
            if (mvn) begin mem_req[0] = 1'b0; mem_we[0] = 1'b0; end
            if (ivn) if_req[0] = 1'b0;
        end
        mem_req[0] = 1'b0; mem_we[0] = 1'b0; if_req[0] = 1'b0;
        chk("both mem_issue_cycle", men, 1);
        chk("both mem_valid_cycle", mv, 3);
        chk("both if_issue_cycle", ien, 5);
        chk("both if_valid_cycle", iv, 7);
        chk("both if_rdata", ird, 32'h2402000A);
        chk("both stall_if_cycles", sif, 7);
        access(0, 1'b1, 1'b0, 10'h010, 32'h0, vc, rd, en_n, en_c, en_a, en_w, st_n);
        chk("both readback", rd, 32'hDEADBEEF);

        // Reset in cycle 2 of a RAM_LAT=3 fetch.
        @(posedge clk); #1;
        if_req[1] = 1'b1; if_addr[1] = 10'h021;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk_zero(1, "midreset");
        if_req[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (if_valid[1] || ram_en[1]) nvalid++;
        end
        chk("midreset no_activity", nvalid, 0);
        access(1, 1'b0, 1'b0, 10'h020, 32'h0, vc, rd, en_n, en_c, en_a, en_w, st_n);
        chk("midreset next valid_cycle", vc, 2 + LAT1);
        chk("midreset next rdata", rd, 32'h12345678);

        // mem_addr changed in cycle 2 of a RAM_LAT=3 load.
        @(posedge clk); #1;
        mem_req[1] = 1'b1; mem_we[1] = 1'b0; mem_addr[1] = 10'h020;
        vc = -1; ea = '0; rd = '0;
        for (int c = 0; c < 20 && vc < 0; c++) begin
            if (c == 2) mem_addr[1] = 10'h004;
            @(negedge clk);
            if (ram_en[1]) ea = ram_addr[1];
            if (c == 2) chk("addrchg ram_addr_in_wait", {22'h0, ram_addr[1]}, 32'h0);
            if (mem_valid[1]) begin vc = c; rd = mem_rdata[1]; end
            @(posedge clk); #1;
        end
        mem_req[1] = 1'b0;
        chk("addrchg issued_addr", {22'h0, ea}, 32'h020);
        chk("addrchg valid_cycle", vc, 2 + LAT1);
        chk("addrchg rdata", rd, 32'h12345678);

        // MEM held continuously against a waiting IF.
        @(posedge clk); #1;
        mem_req[0] = 1'b1; mem_we[0] = 1'b0; mem_addr[0] = 10'h030;
        if_req[0] = 1'b1; if_addr[0] = 10'h004;
        stop = 1'b0; mem_g = 0; if_g_at = -1; ird = '0;
        for (int c = 0; c < 150 && (mem_req[0] || if_req[0]); c++) begin
            if (c == 40) stop = 1'b1;
            @(negedge clk);
            if (ram_en[0]) begin
                if (ram_addr[0] == 10'h030) begin
                    if (if_g_at < 0) mem_g++;
                end else if (ram_addr[0] == 10'h004) begin
                    if (if_g_at < 0) if_g_at = c;
                end
            end
            mvn = mem_valid[0]; ivn = if_valid[0];
            if (ivn) ird = if_rdata[0];
            @(posedge clk); #1;
            if (ivn) if_req[0] = 1'b0;
            if (mvn && stop) mem_req[0] = 1'b0;
        end
        chk("starve requests_released", {30'h0, mem_req[0], if_req[0]}, 32'h0);
        mem_req[0] = 1'b0; if_req[0] = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        chk("starve mem_grants_before_if", mem_g, 4);
        chk("starve if_issue_cycle", if_g_at, 17);
`else
        chk("starve mem_grants_before_if", mem_g, 11);
        chk("starve if_issue_cycle", if_g_at, 45);
`endif
        chk("starve if_rdata", ird, 32'h2402000A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the IF-stage fetch port and the MEM-stage load/store port of the 5-stage MIPS pipeline.
- Serialises accesses and grants MEM priority, since MEM holds the older instruction.
- Drives per-port stall outputs, which the hazard unit ORs into pc_write / IF_ID_write and the EX/MEM/WB enables.
- Sits between the pipeline registers and the memory macro.

Parameters:
- ADDR_W, 10, word-address width of the RAM.
- DATA_W, 32, data width.
- RAM_LAT, 1, cycles from ram_en to valid ram_rdata; legal range 1..7.
- STARVE_MAX, 4, consecutive IF losses before IF is forced to win (optional feature only).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; level, held until if_valid.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  DATA_W  fetched instruction.
- if_valid  out  1  one-cycle completion pulse.
- stall_if  out  1  IF must hold.
- mem_req  in  1  data request; level, held until mem_valid.
- mem_we  in  1  1 = store, 0 = load.
- mem_addr  in  ADDR_W  data word address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data.
- mem_valid  out  1  one-cycle completion pulse.
- stall_mem  out  1  MEM must hold.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write strobe.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; all outputs 0, including if_rdata and mem_rdata.
- Reset mid-access aborts the access; no valid pulse is produced for it.
- States: IDLE, ISSUE, WAIT, DONE. An owner register records IF or MEM.
- IDLE:
  - If mem_req=1, owner=MEM; latch mem_addr, mem_we, mem_wdata; go to ISSUE.
  - Else if if_req=1, owner=IF; latch if_addr; go to ISSUE.
  - Else stay in IDLE.
- ISSUE:
  - Lasts one cycle. ram_en=1, ram_we=latched we (always 0 for IF), ram_addr and ram_wdata from the latches.
  - Latency counter loaded with RAM_LAT-1. Go to WAIT, or to DONE directly if RAM_LAT=1.
- WAIT: decrement the counter; go to DONE when it reaches 0.
- DONE:
  - Sample ram_rdata into the owner's rdata register (stores leave mem_rdata unchanged).
  - Pulse the owner's valid for exactly one cycle, registered.
  - Go to IDLE.
- Latency: request seen in cycle 0 gives ram_en in cycle 1 and valid plus data in cycle 2+RAM_LAT. With RAM_LAT=1, valid arrives in cycle 3.
- Back-to-back accesses: one idle bubble after each DONE.
- Requester inputs (address, we, wdata) are ignored after the latch; changes during an access have no effect.
- Stalls: stall_if = if_req & ~if_valid; stall_mem = mem_req & ~mem_valid. These are combinational on registered valid, so both drop in the completion cycle.
- A request still high in the IDLE cycle after completion is treated as a new request; the pipeline advanced on the valid edge.
- Simultaneous if_req and mem_req in IDLE: MEM wins. IF keeps stalling and is served next.
- A request deasserted before grant is dropped silently. Deassertion after grant is illegal (the verification bench asserts on it).
- ram_en is high for exactly one cycle per access. The RAM control outputs are 0 in every state other than ISSUE.
- rdata registers hold their value until the next completion for that port.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - A saturating counter, width $clog2(STARVE_MAX+1), increments each time IDLE grants MEM while if_req=1, and clears on any IF grant.
  - When it equals STARVE_MAX, the next IDLE arbitration grants IF even if mem_req=1.
- Undefined: strict MEM priority; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
  - typedef enum logic {OWN_IF, OWN_MEM} arb_owner_t;
  - localparam MAX_RAM_LAT = 7.
- One sub-module, arb_lat_counter: a loadable down-counter with a zero flag, reused for the latency count.
- The starve counter stays inline.

Test Plan:
- RAM_LAT=1; if_req=1, if_addr=0x004, RAM word 4 = 0x2402000A -> ram_en in cycle 1 with addr 0x004; if_valid=1 and if_rdata=0x2402000A in cycle 3; stall_if high in cycles 0–2 only.
- if_req and mem_req both raised in cycle 0, mem_we=1, mem_addr=0x010, wdata=0xDEADBEEF -> MEM is served first (mem_valid in cycle 3); IF is issued in cycle 5 and if_valid arrives in cycle 7; read of 0x010 afterwards returns 0xDEADBEEF.
- RAM_LAT=3; load from 0x020 holding 0x12345678 -> mem_valid in cycle 5; ram_en is asserted only in cycle 1.
- Reset asserted in cycle 2 of a RAM_LAT=3 fetch -> all outputs 0 at once; no if_valid after release; the next request completes normally.
- mem_req held continuously, if_req=1, STARVE_MAX=4, ARB_STARVE_GUARD_EN defined -> IF is granted after exactly 4 MEM grants. With the macro undefined, IF is never granted while mem_req stays high.
- mem_addr changed in cycle 2 of an access -> ram_addr is unaffected and the original address's data is returned.
